// File: rtl/serial_tc_pkg.sv
// Shared types and constants for the bit-serial two's-complement negation block.
package serial_tc_pkg;

  localparam int TC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } tc_state_e;

endpackage

// File: rtl/serial_tc_cell.sv
// Serial complement cell: passes bits unchanged up to and including the first 1,
// inverts every bit after it (LSB-first two's-complement negation).
module serial_tc_cell (
  input  logic clk,
  input  logic r,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clr)     seen_d = 1'b0;
    else if (en) seen_d = seen_q | bit_in;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) seen_q <= 1'b0;
    else   seen_q <= seen_d;
  end

  assign bit_out = seen_q ? ~bit_in : bit_in;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Word-level sequencer: accepts a parallel word, negates it one bit per clock
// through serial_tc_cell, and presents the collected result on an output handshake.
module serial_negate_ctrl
  import serial_tc_pkg::*;
#(
  parameter int W = TC_W
) (
  input  logic         clk,
  input  logic         r,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         busy
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(W - 1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

  tc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             cell_clr, cell_en, cell_y;

  serial_tc_cell u_cell (
    .clk    (clk),
    .r      (r),
    .clr    (cell_clr),
    .en     (cell_en),
    .bit_in (opnd_q[0]),
    .bit_out(cell_y)
  );

  assign in_ready = (state_q == IDLE) && !r;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    cell_clr = 1'b0;
    cell_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          opnd_d   = in_data;
          cnt_d    = '0;
          cell_clr = 1'b1;
          ovf_d    = (in_data == MOST_NEG);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        cell_en = 1'b1;
        res_d   = {cell_y, res_q[W-1:1]};
        opnd_d  = opnd_q >> 1;
        // Counter parks at LAST rather than wrapping; it is reloaded on accept.
        if (cnt_q == LAST) state_d = HOLD;
        else               cnt_d   = cnt_q + CNT_W'(1);
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered copies of the next state.
    vld_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl (W=8) with an expected-result queue.
module tb_serial_negate_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   hs_cyc = 0;
  int   busy_cnt = 0;

  serial_negate_ctrl #(.W(W)) dut (
    .clk      (clk),
    .r        (r),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    e.d = W'(0 - int'(d));
    e.o = (d == 8'h80);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 40) begin step(); t++; end
    chk("accept_ready", in_ready, 1);
    sb.push_back(model(d));
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic recv(input int hold_low);
    int           t;
    logic [W-1:0] d0;
    exp_t         e;
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin step(); t++; end
    chk("latency", cyc - acc_cyc, W);
    d0 = out_data;
    for (int i = 0; i < hold_low; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, d0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("out_data", out_data, e.d);
      chk("out_ovf", out_ovf, e.o);
    end
    step();
    hs_cyc    = cyc;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ops[3];
    int           acc_t[3];
    int           nacc, got, t;
    exp_t         e;

    r = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    r = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Basic word with busy-duration check.
    busy_cnt = 0;
    send(8'h01);
    recv(0);
    chk("busy_cycles", busy_cnt, W + 1);

    send(8'h06); recv(0);
    send(8'h7F); recv(0);
    send(8'h00); recv(0);
    send(8'h80); recv(0);

    // Back-pressure with a pending producer word.
    send(8'h06);
    in_valid = 1'b1;
    in_data  = 8'h33;
    recv(5);
    send(8'h33);
    chk("pending_accept_cyc", acc_cyc, hs_cyc + 1);
    recv(0);

    // Reset during SHIFT discards the word.
    send(8'h5A);
    step(); step();
    chk("mid_busy", busy, 1);
    r = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    sb.delete();
    step();
    r = 1'b0;
    step();
    send(8'h02); recv(0);

    // Streaming with continuous valid/ready.
    ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h03;
    nacc = 0; got = 0; t = 0;
    in_valid = 1'b1; in_data = ops[0]; out_ready = 1'b1;
    while (got < 3 && t < 80) begin
      logic took;
      took = 1'b0;
      if (in_valid && in_ready && nacc < 3) begin
        sb.push_back(model(in_data));
        acc_t[nacc] = cyc + 1;
        nacc++;
        took = 1'b1;
      end
      if (out_valid) begin
        if (sb.size() == 0) chk("stream_sb", 0, 1);
        else begin
          e = sb.pop_front();
          chk("stream_data", out_data, e.d);
          chk("stream_ovf", out_ovf, e.o);
        end
        got++;
      end
      step();
      t++;
      if (took) begin
        if (nacc < 3) in_data = ops[nacc];
        else          in_valid = 1'b0;
      end
    end
    chk("stream_count", got, 3);
    if (nacc == 3) begin
      chk("stream_gap0", acc_t[1] - acc_t[0], W + 2);
      chk("stream_gap1", acc_t[2] - acc_t[1], W + 2);
    end else begin
      chk("stream_accepts", nacc, 3);
    end
    out_ready = 1'b0;
    step();
    chk("end_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
